// File: rtl/ncl_wavefront_driver.sv
// Drives one four-phase NCL wavefront (DATA then NULL) per stimulus vector
// onto a dual-rail gate under test and captures the single-output response.
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_STIM | rails at NULL, idle, accepting the next stimulus vector
// DATA_PH   | DATA driven, waiting for exactly one output rail high
// NULL_PH   | NULL driven, waiting for both output rails low
// ERROR     | timeout or illegal output seen; rails NULL until rst
module ncl_wavefront_driver #(
    parameter int INPUT_PORTS = 3,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_PORTS-1:0] stm_value,
    input  logic                   stm_valid,
    output logic                   stm_ack,
    output logic [INPUT_PORTS-1:0] din_t,
    output logic [INPUT_PORTS-1:0] din_f,
    input  logic                   dut_t,
    input  logic                   dut_f,
    output logic                   resp_valid,
    output logic                   resp_value,
    output logic [INPUT_PORTS-1:0] resp_stim,
    output logic [CNT_W-1:0]       vec_count,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_illegal
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TC_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_STIM,
        DATA_PH,
        NULL_PH,
        ERROR
    } state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          tmr, tmr_n;
    logic [INPUT_PORTS-1:0] din_t_n, din_f_n, resp_stim_n;
    logic                   stm_ack_n, resp_valid_n, resp_value_n;
    logic                   busy_n, err_timeout_n, err_illegal_n;
    logic [CNT_W-1:0]       vec_count_n;

    // Phase timer counts down from TIMEOUT-1; expiry at zero is the
    // TIMEOUT-th sampling edge of the phase. Completion is tested first,
    // so a response on the terminal edge still counts as completion.
    always_comb begin
        state_n       = state;
        tmr_n         = tmr;
        din_t_n       = din_t;
        din_f_n       = din_f;
        stm_ack_n     = 1'b0;
        resp_valid_n  = 1'b0;
        resp_value_n  = resp_value;
        resp_stim_n   = resp_stim;
        vec_count_n   = vec_count;
        err_timeout_n = err_timeout;
        err_illegal_n = err_illegal;

        case (state)
            WAIT_STIM: begin
                if (stm_valid) begin
                    stm_ack_n   = 1'b1;
                    din_t_n     = stm_value;
                    din_f_n     = ~stm_value;
                    resp_stim_n = stm_value;
                    tmr_n       = TC_LOAD;
                    state_n     = DATA_PH;
                end
            end
            DATA_PH: begin
                if (dut_t && dut_f) begin
                    err_illegal_n = 1'b1;
                    din_t_n       = '0;
                    din_f_n       = '0;
                    state_n       = ERROR;
                end else if (dut_t ^ dut_f) begin
                    resp_value_n = dut_t;
                    resp_valid_n = 1'b1;
                    din_t_n      = '0;
                    din_f_n      = '0;
                    tmr_n        = TC_LOAD;
                    state_n      = NULL_PH;
                end else if (tmr == '0) begin
                    err_timeout_n = 1'b1;
                    din_t_n       = '0;
                    din_f_n       = '0;
                    state_n       = ERROR;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            NULL_PH: begin
                if (dut_t && dut_f) begin
                    err_illegal_n = 1'b1;
                    state_n       = ERROR;
                end else if (!dut_t && !dut_f) begin
                    vec_count_n = vec_count + 1'b1;
                    state_n     = WAIT_STIM;
                end else if (tmr == '0) begin
                    err_timeout_n = 1'b1;
                    state_n       = ERROR;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            ERROR: begin
                din_t_n = '0;
                din_f_n = '0;
            end
            default: begin
                din_t_n = '0;
                din_f_n = '0;
                state_n = ERROR;
            end
        endcase

        busy_n = (state_n != WAIT_STIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_STIM;
            tmr         <= '0;
            din_t       <= '0;
            din_f       <= '0;
            stm_ack     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_value  <= 1'b0;
            resp_stim   <= '0;
            vec_count   <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            din_t       <= din_t_n;
            din_f       <= din_f_n;
            stm_ack     <= stm_ack_n;
            resp_valid  <= resp_valid_n;
            resp_value  <= resp_value_n;
            resp_stim   <= resp_stim_n;
            vec_count   <= vec_count_n;
            busy        <= busy_n;
            err_timeout <= err_timeout_n;
            err_illegal <= err_illegal_n;
        end
    end

endmodule

// File: tb/tb_ncl_wavefront_driver.sv
// Directed bench for ncl_wavefront_driver: loopback gate model plus forced
// output rails for timeout, illegal-code, late-response and reset cases.
module tb_ncl_wavefront_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] stm_value = '0;
    logic       stm_valid = 1'b0;

    logic       stm_ack, resp_valid, resp_value, busy, err_timeout, err_illegal;
    logic [2:0] din_t, din_f, resp_stim;
    logic [15:0] vec_count;
    logic       dut_t, dut_f;

    logic       w_ack, w_rv, w_rval, w_busy, w_et, w_ei;
    logic [2:0] w_din_t, w_din_f, w_rstim;
    logic [2:0] w_vec;
    logic       w_dut_t, w_dut_f;

    logic lb_mode = 1'b1;
    logic frc_t = 1'b0, frc_f = 1'b0;
    logic lb_t = 1'b0, lb_f = 1'b0, wlb_t = 1'b0, wlb_f = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Loopback gate: OR of true rails, AND of false rails, one cycle late.
    always @(posedge clk) begin
        lb_t  <= din_t[0] | din_t[1];
        lb_f  <= din_f[0] & din_f[1];
        wlb_t <= w_din_t[0] | w_din_t[1];
        wlb_f <= w_din_f[0] & w_din_f[1];
    end

    assign dut_t   = lb_mode ? lb_t  : frc_t;
    assign dut_f   = lb_mode ? lb_f  : frc_f;
    assign w_dut_t = lb_mode ? wlb_t : frc_t;
    assign w_dut_f = lb_mode ? wlb_f : frc_f;

    ncl_wavefront_driver #(.INPUT_PORTS(3), .TIMEOUT(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .stm_value(stm_value), .stm_valid(stm_valid),
        .stm_ack(stm_ack), .din_t(din_t), .din_f(din_f), .dut_t(dut_t), .dut_f(dut_f),
        .resp_valid(resp_valid), .resp_value(resp_value), .resp_stim(resp_stim),
        .vec_count(vec_count), .busy(busy), .err_timeout(err_timeout),
        .err_illegal(err_illegal)
    );

    ncl_wavefront_driver #(.INPUT_PORTS(3), .TIMEOUT(16), .CNT_W(3)) u_wrap (
        .clk(clk), .rst(rst), .stm_value(stm_value), .stm_valid(stm_valid),
        .stm_ack(w_ack), .din_t(w_din_t), .din_f(w_din_f), .dut_t(w_dut_t), .dut_f(w_dut_f),
        .resp_valid(w_rv), .resp_value(w_rval), .resp_stim(w_rstim),
        .vec_count(w_vec), .busy(w_busy), .err_timeout(w_et), .err_illegal(w_ei)
    );

    task automatic do_reset();
        rst = 1'b1;
        stm_valid = 1'b0;
        stm_value = '0;
        lb_mode = 1'b1;
        frc_t = 1'b0;
        frc_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends one vector and waits (bounded) for the response and return to idle.
    task automatic run_vec(input logic [2:0] v, output logic ackd, output logic got,
                           output logic rv);
        stm_value = v;
        stm_valid = 1'b1;
        @(posedge clk);
        #1;
        ackd = stm_ack;
        stm_valid = 1'b0;
        got = 1'b0;
        rv = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                got = 1'b1;
                rv = resp_value;
                break;
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        if (busy) got = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({stm_ack, din_t, din_f, resp_valid, resp_value, resp_stim, busy,
             err_timeout, err_illegal} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", {stm_ack, din_t, din_f,
                     resp_valid, resp_value, resp_stim, busy, err_timeout, err_illegal});
        end
        n_cmp++;
        if (vec_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_vec_count got %0d want 0", vec_count);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_r = 8'b1110_1110;
        logic ackd, got, rv;
        do_reset();
        for (int v = 0; v < 8; v++) begin
            run_vec(v[2:0], ackd, got, rv);
            n_cmp++;
            if ({ackd, got} !== 2'b11) begin
                n_bad++;
                $display("FAIL loop_handshake v=%0d got ack=%b resp=%b want 1 1", v, ackd, got);
            end
            n_cmp++;
            if (rv !== exp_r[v]) begin
                n_bad++;
                $display("FAIL loop_resp_value v=%0d got %b want %b", v, rv, exp_r[v]);
            end
            n_cmp++;
            if (resp_stim !== v[2:0]) begin
                n_bad++;
                $display("FAIL loop_resp_stim got %b want %b", resp_stim, v[2:0]);
            end
        end
        n_cmp++;
        if (vec_count !== 16'd8) begin
            n_bad++;
            $display("FAIL loop_vec_count got %0d want 8", vec_count);
        end
        n_cmp++;
        if ({err_timeout, err_illegal} !== 2'b00) begin
            n_bad++;
            $display("FAIL loop_errors got %b want 00", {err_timeout, err_illegal});
        end
    endtask

    task automatic test_ack_latency();
        do_reset();
        stm_value = 3'b101;
        stm_valid = 1'b1;
        @(posedge clk);
        #1;
        stm_valid = 1'b0;
        n_cmp++;
        if ({stm_ack, din_t, din_f, resp_stim, busy} !== {1'b1, 3'b101, 3'b010, 3'b101, 1'b1}) begin
            n_bad++;
            $display("FAIL ack_edge got ack=%b t=%b f=%b stim=%b busy=%b want 1 101 010 101 1",
                     stm_ack, din_t, din_f, resp_stim, busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (stm_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_pulse_width got %b want 0", stm_ack);
        end
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({busy, vec_count} !== {1'b0, 16'd1}) begin
            n_bad++;
            $display("FAIL ack_complete got busy=%b cnt=%0d want 0 1", busy, vec_count);
        end
    endtask

    task automatic test_timeout();
        logic ack_seen;
        do_reset();
        lb_mode = 1'b0;
        stm_value = 3'b011;
        stm_valid = 1'b1;
        @(posedge clk);
        #1;
        stm_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if ({err_timeout, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_early got et=%b busy=%b want 0 1", err_timeout, busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({err_timeout, err_illegal, din_t, din_f, busy, resp_valid} !== {2'b10, 6'd0, 2'b10}) begin
            n_bad++;
            $display("FAIL timeout_edge got et=%b ei=%b t=%b f=%b busy=%b rv=%b want 1 0 000 000 1 0",
                     err_timeout, err_illegal, din_t, din_f, busy, resp_valid);
        end
        ack_seen = 1'b0;
        stm_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            ack_seen |= stm_ack;
        end
        stm_valid = 1'b0;
        n_cmp++;
        if ({ack_seen, err_timeout, busy} !== 3'b011) begin
            n_bad++;
            $display("FAIL timeout_sticky got ack=%b et=%b busy=%b want 0 1 1", ack_seen, err_timeout, busy);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        lb_mode = 1'b0;
        stm_value = 3'b110;
        stm_valid = 1'b1;
        @(posedge clk);
        #1;
        stm_valid = 1'b0;
        frc_t = 1'b1;
        frc_f = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({err_illegal, err_timeout, resp_valid, busy, din_t, din_f} !== {4'b1001, 6'd0}) begin
            n_bad++;
            $display("FAIL illegal_edge got ei=%b et=%b rv=%b busy=%b t=%b f=%b want 1 0 0 1 000 000",
                     err_illegal, err_timeout, resp_valid, busy, din_t, din_f);
        end
        frc_t = 1'b0;
        frc_f = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({err_illegal, busy, resp_valid, vec_count} !== {3'b110, 16'd0}) begin
            n_bad++;
            $display("FAIL illegal_stuck got ei=%b busy=%b rv=%b cnt=%0d want 1 1 0 0",
                     err_illegal, busy, resp_valid, vec_count);
        end
    endtask

    task automatic test_late_resp_and_reset();
        do_reset();
        lb_mode = 1'b0;
        stm_value = 3'b001;
        stm_valid = 1'b1;
        @(posedge clk);
        #1;
        stm_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        frc_t = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({resp_valid, resp_value, err_timeout, din_t, din_f} !== {3'b110, 6'd0}) begin
            n_bad++;
            $display("FAIL late_resp got rv=%b val=%b et=%b t=%b f=%b want 1 1 0 000 000",
                     resp_valid, resp_value, err_timeout, din_t, din_f);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, err_timeout, vec_count} !== {2'b10, 16'd0}) begin
            n_bad++;
            $display("FAIL null_hold got busy=%b et=%b cnt=%0d want 1 0 0", busy, err_timeout, vec_count);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        frc_t = 1'b0;
        n_cmp++;
        if ({stm_ack, din_t, din_f, resp_valid, resp_value, resp_stim, vec_count, busy,
             err_timeout, err_illegal} !== 31'd0) begin
            n_bad++;
            $display("FAIL mid_null_reset got %h want 0", {stm_ack, din_t, din_f, resp_valid,
                     resp_value, resp_stim, vec_count, busy, err_timeout, err_illegal});
        end
    endtask

    task automatic test_wrap();
        int exp_w[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        logic ackd, got, rv;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_vec(3'(i + 2), ackd, got, rv);
            n_cmp++;
            if ({got, w_vec, vec_count} !== {1'b1, 3'(exp_w[i]), 16'(i + 1)}) begin
                n_bad++;
                $display("FAIL wrap_count i=%0d got done=%b w=%0d full=%0d want 1 %0d %0d",
                         i, got, w_vec, vec_count, exp_w[i], i + 1);
            end
        end
        n_cmp++;
        if ({w_et, w_ei, w_busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL wrap_errors got %b want 000", {w_et, w_ei, w_busy});
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_ack_latency();
        test_timeout();
        test_illegal();
        test_late_resp_and_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ncl_wavefront_driver.md
Name: ncl_wavefront_driver

Overview:
- Sits directly downstream of signal_gen. Consumes its binary stimulus vectors (stm_value) and turns each one into an NCL four-phase wavefront on the dual-rail inputs of a single-output gate under test.
- Each vector produces a DATA wavefront followed by a NULL wavefront. The block waits for the gate output to reach DATA, then to return to NULL, with a cycle timeout on each phase.
- It reports every completed response, counts completed vectors, and flags protocol errors. Bench-side block only; not for synthesis into the design.

Parameters:
- INPUT_PORTS, 3, number of gate inputs; width of stm_value and of each input rail bus.
- TIMEOUT, 16, maximum clk cycles allowed per phase (DATA or NULL) before err_timeout; must be >= 2.
- CNT_W, 16, width of vec_count.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stm_value  input  INPUT_PORTS  binary stimulus vector from signal_gen.
- stm_valid  input  1  stm_value is valid; held until stm_ack.
- stm_ack  output  1  one-cycle pulse: vector accepted.
- din_t  output  INPUT_PORTS  true rails to gate under test.
- din_f  output  INPUT_PORTS  false rails to gate under test.
- dut_t  input  1  gate output true rail.
- dut_f  input  1  gate output false rail.
- resp_valid  output  1  one-cycle pulse: response captured.
- resp_value  output  1  captured response (1 = dut_t asserted).
- resp_stim  output  INPUT_PORTS  stimulus that produced resp_value.
- vec_count  output  CNT_W  count of completed vectors (full DATA+NULL cycle).
- busy  output  1  high in any state except WAIT_STIM.
- err_timeout  output  1  sticky: a phase exceeded TIMEOUT.
- err_illegal  output  1  sticky: dut_t and dut_f both high.

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst high at an edge): state=WAIT_STIM; din_t=din_f=0 (NULL); stm_ack, resp_valid, resp_value, resp_stim, vec_count, err_timeout, err_illegal, busy are all 0. Reset takes priority over everything, including mid-phase and the ERROR state.
- States: WAIT_STIM, DATA_PH, NULL_PH, ERROR.
- WAIT_STIM, with stm_valid=1 sampled at edge k:
  - At edge k the block registers stm_ack=1 for one cycle, din_t=stm_value, din_f=~stm_value, stores the vector into resp_stim, sets phase counter=0 and goes to DATA_PH.
  - Latency from stm_valid to the rails: 1 cycle.
  - stm_valid while busy is ignored (no ack).
- DATA_PH, checks at each edge in this priority:
  - dut_t&dut_f: err_illegal=1, go to ERROR.
  - Exactly one rail high: resp_value=dut_t, resp_valid=1 for one cycle, din_t=din_f=0, counter=0, go to NULL_PH.
  - Counter==TIMEOUT-1: err_timeout=1, go to ERROR.
  - Otherwise: counter+1.
- NULL_PH, checks at each edge:
  - dut_t&dut_f: go to ERROR with err_illegal=1.
  - Both rails low: vec_count+1, go to WAIT_STIM.
  - Counter==TIMEOUT-1: go to ERROR with err_timeout=1.
  - Otherwise: counter+1.
- A gate that needs 0 cycles (output already settled at the first sampling edge) completes in 1 cycle. A completion seen on the same edge as counter==TIMEOUT-1 counts as completion, not timeout.
- ERROR: din_t=din_f=0. The block stays there until rst; stm_valid is ignored; busy=1.
- vec_count wraps modulo 2^CNT_W.
- Invariant: din_t&din_f == 0 in every cycle.

Test Plan:
- Loopback model dut_t=din_t[0]|din_t[1], dut_f=din_f[0]&din_f[1], 1-cycle delay; feed stm_value 3'b000..3'b111 -> 8 resp_valid pulses with resp_value 0,1,1,1,0,1,1,1 (tracking bits[1:0]); vec_count=8; no errors.
- stm_valid=1 with stm_value=3'b101 at edge k -> stm_ack=1 and din_t=3'b101, din_f=3'b010 after edge k; stm_ack low one cycle later.
- dut_t, dut_f held 0 after DATA is driven, TIMEOUT=16 -> err_timeout=1 exactly 16 cycles after DATA entry; rails return to NULL; later stm_valid is ignored.
- dut_t=dut_f=1 during DATA_PH -> err_illegal=1 on the next edge, state ERROR, no resp_valid.
- Output responds on the 16th DATA cycle (counter==15) -> completion, no timeout. rst asserted mid-NULL_PH -> all outputs 0 and WAIT_STIM after one edge.
- CNT_W=3, 9 vectors -> vec_count sequence wraps 7->0, ends at 1.
